// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the multi-digit 7-segment display controller:
//   - SEG_FONT  : 16-entry active-low hex font, bits {dp,g,f,e,d,c,b,a}
//   - SEG_BLANK : all segments and dp off
//   - SEG_A..SEG_G, SEG_DP : bit positions inside a segment byte
//   - state_e   : controller FSM encoding (ST_IDLE, ST_DECODE)
//   - seg_font_lookup : nibble + dp request to active-low segment byte
// -----------------------------------------------------------------------------
package seg7_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Entry [n] is the glyph for hex value n; listed F down to 0 because the
   // leftmost element of a packed concatenation is the highest index.
   localparam logic [15:0][7:0] SEG_FONT = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_DECODE = 1'b1
   } state_e;

   // Active low: a lit decimal point clears the dp bit.
   function automatic logic [7:0] seg_font_lookup(input logic [3:0] nib,
                                                  input logic       dp);
      logic [7:0] code;
      code         = SEG_FONT[nib];
      code[SEG_DP] = ~dp;
      return code;
   endfunction

endpackage

// File: rtl/seg7_font.sv
// -----------------------------------------------------------------------------
// seg7_font
// Combinational hex font decoder shared by all digits of the display.
// Ports:
//   nib_i  [3:0] hex value to display
//   dp_i         decimal point request, 1 = lit
//   code_o [7:0] active-low segment byte {dp,g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg7_font
   import seg7_pkg::*;
(
   input  logic [3:0] nib_i,
   input  logic       dp_i,
   output logic [7:0] code_o
);

   assign code_o = seg_font_lookup(nib_i, dp_i);

endmodule

// File: rtl/seg7_display_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_display_ctrl
// Registered multi-digit hex display controller. A NUM_DIGITS-nibble word is
// accepted over a valid/ready handshake and decoded one digit per cycle, MSB
// digit first, through a single shared font decoder into per-digit shadow
// registers. seg_n is registered from the shadow registers.
//
// Optional feature macro: SEG_BLINK_EN
//   defined   : prescaler + blink phase built; masked digits blank on phase 1
//   undefined : blink_phase tied to 0, blink_mask has no effect
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   load_valid  new display word offered
//   load_ready  controller idle and able to accept a word
//   load_data   [4*NUM_DIGITS] nibble k = digit k, digit 0 rightmost
//   load_dp     [NUM_DIGITS]   decimal point per digit, 1 = lit
//   blank_lz    leading-zero blanking enable, sampled at load
//   blink_mask  [NUM_DIGITS]   per-digit blink enable, sampled every cycle
//   seg_n       [8*NUM_DIGITS] byte k = digit k, {dp,g,f,e,d,c,b,a}, active low
// -----------------------------------------------------------------------------
module seg7_display_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 6,
   parameter int BLINK_DIV  = 25000000
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [4*NUM_DIGITS-1:0] load_data,
   input  logic [NUM_DIGITS-1:0]   load_dp,
   input  logic                    blank_lz,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   output logic [8*NUM_DIGITS-1:0] seg_n
);

   localparam int  IW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam bit  CFG_OK = (NUM_DIGITS >= 1) && (NUM_DIGITS <= 8) && (BLINK_DIV >= 2);

   if (!CFG_OK) begin : g_bad_cfg
      $error("seg7_display_ctrl: NUM_DIGITS must be 1..8 and BLINK_DIV >= 2");
   end

   state_e                  state_q, state_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic                    lz_q, lz_d;
   logic [4*NUM_DIGITS-1:0] data_q, data_d;
   logic [NUM_DIGITS-1:0]   dp_q, dp_d;

   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    cur_blank;
   logic [7:0]              font_code;
   logic [7:0]              shadow_d;
   logic                    blink_phase;

   // Current digit selected by idx; {idx,2'b00} is idx*4 without a multiplier.
   assign cur_nib   = data_q[{idx_q, 2'b00} +: 4];
   assign cur_dp    = dp_q[idx_q];
   // Leading zeros blank until the first nonzero nibble; digit 0 always shows.
   assign cur_blank = lz_q && (cur_nib == 4'h0) && (idx_q != '0);

   seg7_font u_font (
      .nib_i  (cur_nib),
      .dp_i   (cur_dp),
      .code_o (font_code)
   );

   assign shadow_d = cur_blank ? SEG_BLANK : font_code;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         lz_q    <= 1'b0;
         data_q  <= '0;
         dp_q    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         lz_q    <= lz_d;
         data_q  <= data_d;
         dp_q    <= dp_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      lz_d       = lz_q;
      data_d     = data_q;
      dp_d       = dp_q;
      load_ready = 1'b0;
      case (state_q)
         ST_IDLE: begin
            load_ready = ~rst;
            if (load_valid && !rst) begin
               data_d  = load_data;
               dp_d    = load_dp;
               lz_d    = blank_lz;
               idx_d   = IW'(NUM_DIGITS - 1);
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            lz_d  = lz_q && (cur_nib == 4'h0);
            idx_d = idx_q - 1'b1;
            if (idx_q == '0) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef SEG_BLINK_EN
   localparam int PW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

   logic [PW-1:0] presc_q;
   logic          phase_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
         phase_q <= 1'b0;
      end else if (presc_q == PW'(BLINK_DIV - 1)) begin
         presc_q <= '0;
         phase_q <= ~phase_q;
      end else begin
         presc_q <= presc_q + 1'b1;
      end
   end

   assign blink_phase = phase_q;
`else
   assign blink_phase = 1'b0;
`endif

   // Per-digit shadow register and output register.
   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [7:0] shadow_q;
      logic [7:0] seg_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            shadow_q <= SEG_BLANK;
         end else if ((state_q == ST_DECODE) && (idx_q == IW'(gi))) begin
            shadow_q <= shadow_d;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            seg_q <= SEG_BLANK;
         end else begin
            seg_q <= (blink_phase && blink_mask[gi]) ? SEG_BLANK : shadow_q;
         end
      end

      assign seg_n[8*gi +: 8] = seg_q;
   end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_display_ctrl
// Scoreboard bench: each issued word pushes its expected 48-bit segment image;
// a monitor tracks load_ready low periods and, one cycle after load_ready
// returns high, pops and compares the displayed image.
// -----------------------------------------------------------------------------
module tb_seg7_display_ctrl;

   localparam int N = 6;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            load_valid = 1'b0;
   logic            load_ready;
   logic [4*N-1:0]  load_data = '0;
   logic [N-1:0]    load_dp = '0;
   logic            blank_lz = 1'b0;
   logic [N-1:0]    blink_mask = '0;
   logic [8*N-1:0]  seg_n;

   int n_cmp = 0;
   int n_bad = 0;

   logic [47:0] exp_q[$];
   bit          busy = 0;
   bit          pending = 0;
   int          low_cnt = 0;

   always #5 clk = ~clk;

   seg7_display_ctrl #(
      .NUM_DIGITS (N),
      .BLINK_DIV  (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_dp    (load_dp),
      .blank_lz   (blank_lz),
      .blink_mask (blink_mask),
      .seg_n      (seg_n)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   // Monitor: sample on negedge, away from the active edge.
   always @(negedge clk) begin
      if (rst) begin
         busy    = 0;
         pending = 0;
      end else begin
         if (pending) begin
            pending = 0;
            if (exp_q.size() == 0) begin
               check("scoreboard_empty", 64'(seg_n), 64'hDEAD);
            end else begin
               check("display", 64'(seg_n), 64'(exp_q.pop_front()));
            end
         end
         if (!load_ready) begin
            if (!busy) begin
               busy    = 1;
               low_cnt = 0;
            end
            low_cnt++;
         end else if (busy) begin
            busy    = 0;
            check("ready_low_cycles", 64'(low_cnt), 64'(N));
            pending = 1;
         end
      end
   end

   task automatic wait_ready();
      int k;
      k = 0;
      while (!load_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!load_ready) check("ready_timeout", 64'(load_ready), 64'd1);
   endtask

   // Issue one word at a negedge; accepted at the following posedge.
   task automatic send(input logic [23:0] d, input logic [5:0] dp, input logic blz,
                       input logic [47:0] exp, input bit push);
      wait_ready();
      load_valid = 1'b1;
      load_data  = d;
      load_dp    = dp;
      blank_lz   = blz;
      if (push) exp_q.push_back(exp);
      @(posedge clk);
      @(negedge clk);
      load_valid = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((exp_q.size() != 0 || pending || busy) && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (k >= 100) check("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      logic [7:0] v;
      logic [7:0] alt;
      int         k;

      // 1. Reset held for 3 cycles
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_ready", 64'(load_ready), 64'd0);
      end
      check("rst_seg", 64'(seg_n), 64'hFFFFFFFFFFFF);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 64'(load_ready), 64'd1);

      // 2. Basic load
      send(24'h0123AF, 6'b000000, 1'b0, 48'hC0F9A4B0888E, 1);
      drain();

      // 3. Leading-zero blanking and boundaries
      send(24'h000000, 6'b000000, 1'b1, 48'hFFFFFFFFFFC0, 1);
      send(24'h000A05, 6'b000010, 1'b1, 48'hFFFFFF884092, 1);
      send(24'h000000, 6'b111111, 1'b1, 48'hFFFFFFFFFF40, 1);
      send(24'h000000, 6'b000000, 1'b0, 48'hC0C0C0C0C0C0, 1);
      send(24'h100001, 6'b000000, 1'b1, 48'hF9C0C0C0C0F9, 1);
      drain();

      // 4. Handshake: valid held through DECODE with a different word
      send(24'h456789, 6'b100000, 1'b0, 48'h199282F88090, 1);
      load_valid = 1'b1;
      load_data  = 24'h00BCDE;
      load_dp    = 6'b000000;
      blank_lz   = 1'b1;
      exp_q.push_back(48'hFFFF83C6A186);
      k = 0;
      while (!load_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!load_ready) check("hs_ready_timeout", 64'(load_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      load_valid = 1'b0;
      check("hs_accepted", 64'(load_ready), 64'd0);
      drain();

      // 5. Reset in the middle of a decode
      wait_ready();
      load_valid = 1'b1;
      load_data  = 24'h123456;
      load_dp    = 6'b000000;
      blank_lz   = 1'b0;
      @(posedge clk);                 // edge T
      @(negedge clk);
      load_valid = 1'b0;
      @(posedge clk);                 // T+1
      @(negedge clk);
      @(posedge clk);                 // T+2
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);                 // T+3
      @(negedge clk);
      check("midrst_seg", 64'(seg_n), 64'hFFFFFFFFFFFF);
      check("midrst_ready", 64'(load_ready), 64'd0);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_ready_after", 64'(load_ready), 64'd1);
      check("midrst_seg_after", 64'(seg_n), 64'hFFFFFFFFFFFF);
      send(24'hFEDCBA, 6'b000000, 1'b0, 48'h8E86A1C68388, 1);
      drain();

      // 6. Blink
      send(24'h000007, 6'b000000, 1'b0, 48'hC0C0C0C0C0F8, 1);
      drain();
      blink_mask = 6'b000001;
`ifdef SEG_BLINK_EN
      @(negedge clk);
      v = seg_n[7:0];
      k = 0;
      while (seg_n[7:0] == v && k < 12) begin
         @(negedge clk);
         k++;
      end
      check("blink_toggles", 64'(seg_n[7:0] != v), 64'd1);
      v   = seg_n[7:0];
      check("blink_value_legal", 64'((v == 8'hF8) || (v == 8'hFF)), 64'd1);
      alt = (v == 8'hF8) ? 8'hFF : 8'hF8;
      for (int i = 0; i < 12; i++) begin
         check("blink_byte0", 64'(seg_n[7:0]), 64'((((i / 4) % 2) == 0) ? v : alt));
         check("blink_upper", 64'(seg_n[47:8]), 64'h C0C0C0C0C0);
         @(negedge clk);
      end
`else
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("noblink_seg", 64'(seg_n), 64'hC0C0C0C0C0F8);
      end
`endif
      blink_mask = '0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout required completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/seg7_display_ctrl.md
Name: seg7_display_ctrl

Overview:
- Registered multi-digit hex display controller for the DE10-Lite HEX displays. It is the parametrised successor of the single-digit combinational hex-to-7-segment decoder.
- Accepts a NUM_DIGITS-nibble word over a valid/ready handshake and decodes it serially, MSB digit first, through one shared font decoder.
- Adds optional leading-zero blanking, per-digit decimal points and optional blinking.
- Sits between processor/debug logic and the board's active-low segment pins.

Parameters:
- NUM_DIGITS, 6, number of digits driven (1..8).
- BLINK_DIV, 25000000, clk cycles per blink phase toggle (>=2); used only when SEG_BLINK_EN is defined.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  new display word offered.
- load_ready  out  1  controller idle and able to accept a word.
- load_data  in  4*NUM_DIGITS  hex nibbles; nibble k = digit k, digit 0 = rightmost.
- load_dp  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
- blank_lz  in  1  leading-zero blanking enable, sampled at load.
- blink_mask  in  NUM_DIGITS  per-digit blink enable, sampled every cycle.
- seg_n  out  8*NUM_DIGITS  byte k = digit k, bits {dp,g,f,e,d,c,b,a}, active low (1 = off).

Behaviour:
- Reset (sync, active-high):
  - seg_n = all 1s (all digits blank, dp off); load_ready = 0 while rst is high.
  - FSM returns to IDLE; shadow registers set to 8'hFF; blink phase = 0; prescaler = 0.
  - load_ready = 1 on the first cycle after rst falls.
- Font, active-low, dp bit clear in code = lit:
  - 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8
  - 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E
  - dp lit clears bit 7.
- FSM states and transitions:
  - IDLE: load_ready = 1. On an edge with load_valid & load_ready, capture load_data, load_dp and blank_lz; set idx = NUM_DIGITS-1 and lz_flag = blank_lz; go to DECODE.
  - DECODE: load_ready = 0. Each cycle, write shadow[idx] = font(nibble[idx]) with the dp bit applied, then decrement idx. After writing idx = 0, return to IDLE.
  - load_valid while in DECODE is ignored; the word is neither captured nor queued.
- Leading-zero blanking (when captured blank_lz = 1):
  - While lz_flag = 1 and nibble = 0 and idx != 0, shadow[idx] = 8'hFF (dp ignored).
  - The first nonzero nibble clears lz_flag.
  - Digit 0 is never blanked; internal zeros are never blanked.
- Timing (handshake accepted at edge T):
  - Digit k shadow is written at edge T+(NUM_DIGITS-k).
  - seg_n is registered from shadow, so digit k is visible after edge T+(NUM_DIGITS-k)+1; the full display is updated after T+NUM_DIGITS+1.
  - load_ready is 0 after edge T and returns to 1 after edge T+NUM_DIGITS.
  - Back-to-back words: maximum throughput is one word per NUM_DIGITS+1 cycles.
- Undecoded digits keep their previous shadow contents until overwritten; there is no tearing guarantee during DECODE.
- Reset mid-DECODE: abort, blank all digits, discard the captured word.
- seg_n output register: seg_n[k] = (blink_phase & blink_mask[k]) ? 8'hFF : shadow[k], registered every cycle.

Optional Feature:
- SEG_BLINK_EN defined:
  - Prescaler counts 0..BLINK_DIV-1; blink_phase toggles on wrap.
  - Digits with blink_mask[k] = 1 go fully blank, dp included, while blink_phase = 1.
- SEG_BLINK_EN undefined:
  - Prescaler and phase register are not built; blink_phase is tied to 0.
  - The blink_mask port is present but ignored; seg_n = shadow delayed one cycle.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry font constant table;
  - SEG_BLANK = 8'hFF;
  - the segment bit-index constants (SEG_A..SEG_G, SEG_DP);
  - the FSM state encoding (ST_IDLE, ST_DECODE).
- One sub-module, seg7_font: combinational 4-bit nibble + dp to 8-bit active-low code, instanced once inside the DECODE datapath.

Test Plan (NUM_DIGITS=6; BLINK_DIV=4 where relevant):
1. Reset: hold rst 3 cycles -> seg_n = 48'hFFFFFFFFFFFF, load_ready = 0 during rst, 1 on the cycle after rst falls.
2. Basic load: load_data = 24'h0123AF, load_dp = 0, blank_lz = 0, accepted at T -> load_ready low T+1..T+6; by T+7 bytes 5..0 = C0,F9,A4,B0,88,8E.
3. Blanking: blank_lz = 1 with 24'h000000 -> bytes 5..0 = FF,FF,FF,FF,FF,C0. Then 24'h000A05 with load_dp = 6'b000010 -> FF,FF,FF,88,40,92.
4. Handshake: load_valid held high during DECODE with a different word -> ignored. The next word is accepted exactly at the cycle load_ready returns high, and its decode completes correctly.
5. Reset mid-operation: assert rst at T+3 of a decode -> seg_n all FF the following cycle; after release, load_ready = 1 and a new load decodes normally.
6. Blink (SEG_BLINK_EN defined): display 24'h000007, blink_mask = 6'b000001 -> byte 0 alternates F8/FF every 4 cycles and bytes 5..1 are steady C0. Without the macro, byte 0 stays F8.
